// File: rtl/bcd_decode_pkg.sv
// Shared constants, types and helpers for the sequential BCD-to-binary decoder.
package bcd_decode_pkg;

  localparam int BCD_DIGIT_W   = 4;
  localparam int BCD_MAX_DIGIT = 9;
  localparam int DECODE_SHIFTS = 8;

  // Work register holds {tens, units, result byte}.
  localparam int WORK_W = 2 * BCD_DIGIT_W + DECODE_SHIFTS;

  // Counter value seen on the edge that performs the final shift.
  localparam logic [3:0] LAST_SHIFT = 4'(DECODE_SHIFTS - 1);

  typedef logic [BCD_DIGIT_W-1:0] digit_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // A captured digit above 9 is not valid BCD.
  function automatic logic digit_invalid(input digit_t d);
    return d > digit_t'(BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_decode_nibble_adjust.sv
// Reverse double-dabble correction for one BCD nibble: values >= 8 lose 3.
module bcd_nibble_adjust
  import bcd_decode_pkg::*;
(
  input  digit_t nib_i,
  output digit_t nib_o
);

  // A set MSB means a "ten" was shifted in from the nibble above; fold it back.
  always_comb begin
    nib_o = (nib_i >= digit_t'(8)) ? nib_i - digit_t'(3) : nib_i;
  end

endmodule

// File: rtl/bcd_decode.sv
// Two-digit BCD to binary converter using sequential reverse double-dabble.
// A conversion takes exactly 8 shift cycles after the start edge.
module bcd_decode
  import bcd_decode_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [BCD_DIGIT_W-1:0] tens,
  input  logic [BCD_DIGIT_W-1:0] unit,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [N-1:0]           binary
);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [WORK_W-1:0]   work_q, work_d;
  logic                bad_q, bad_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [N-1:0]        binary_q, binary_d;

  logic [WORK_W-1:0]   shifted;
  logic [WORK_W-1:0]   corrected;
  logic [WORK_W-1:0]   result_ext;
  digit_t              hi_adj, lo_adj;

  // One right shift of the work register, then per-nibble correction.
  assign shifted = work_q >> 1;

  bcd_nibble_adjust u_adj_hi (
    .nib_i (shifted[WORK_W-1 -: BCD_DIGIT_W]),
    .nib_o (hi_adj)
  );

  bcd_nibble_adjust u_adj_lo (
    .nib_i (shifted[WORK_W-BCD_DIGIT_W-1 -: BCD_DIGIT_W]),
    .nib_o (lo_adj)
  );

  assign corrected  = {hi_adj, lo_adj, shifted[DECODE_SHIFTS-1:0]};
  assign result_ext = {{(WORK_W-DECODE_SHIFTS){1'b0}}, shifted[DECODE_SHIFTS-1:0]};

  // Next-state and datapath: capture in IDLE, shift/correct in SHIFT.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    bad_d    = bad_q;
    done_d   = 1'b0;
    err_d    = err_q;
    binary_d = binary_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = {tens, unit, {DECODE_SHIFTS{1'b0}}};
          bad_d   = digit_invalid(tens) || digit_invalid(unit);
          cnt_d   = 4'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d = corrected;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == LAST_SHIFT) begin
          state_d  = IDLE;
          cnt_d    = 4'd0;
          done_d   = 1'b1;
          err_d    = bad_q;
          binary_d = bad_q ? '0 : result_ext[N-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      work_q   <= '0;
      bad_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      binary_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      bad_q    <= bad_d;
      done_q   <= done_d;
      err_q    <= err_d;
      binary_q <= binary_d;
    end
  end

  assign busy   = (state_q == SHIFT);
  assign done   = done_q;
  assign err    = err_q;
  assign binary = binary_q;

endmodule

// File: tb/tb_bcd_decode.sv
// Directed-vector bench for bcd_decode with hand-computed expected results.
module tb_bcd_decode;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] tens;
  logic [3:0] unit;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] binary;

  int n_vec;
  int n_miss;

  // Values the outputs must hold between done pulses.
  logic [7:0] held_bin;
  logic       held_err;

  bcd_decode #(.N(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .tens   (tens),
    .unit   (unit),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .binary (binary)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One conversion starting now; intr[j] drives start=1 before edge k+j (j=1..8).
  // Digits are forced to 7,7 after capture to show they are not re-sampled.
  task automatic conv(input string tag, input logic [3:0] t, input logic [3:0] u,
                      input logic [7:0] exp_b, input logic exp_e, input logic [8:0] intr);
    tens  = t;
    unit  = u;
    start = 1'b1;
    @(posedge clk); #1;
    check({tag, " busy@k"}, 32'(busy), 32'd1);
    tens  = 4'd7;
    unit  = 4'd7;
    start = intr[1];
    for (int j = 1; j <= 7; j++) begin
      @(posedge clk); #1;
      check($sformatf("%s busy@k+%0d", tag, j), 32'(busy), 32'd1);
      check($sformatf("%s done@k+%0d", tag, j), 32'(done), 32'd0);
      check($sformatf("%s hold_bin@k+%0d", tag, j), 32'(binary), 32'(held_bin));
      check($sformatf("%s hold_err@k+%0d", tag, j), 32'(err), 32'(held_err));
      start = intr[j+1];
    end
    @(posedge clk); #1;
    check({tag, " done@k+8"}, 32'(done), 32'd1);
    check({tag, " busy@k+8"}, 32'(busy), 32'd0);
    check({tag, " binary"}, 32'(binary), 32'(exp_b));
    check({tag, " err"}, 32'(err), 32'(exp_e));
    held_bin = exp_b;
    held_err = exp_e;
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, " done@k+9"}, 32'(done), 32'd0);
    check({tag, " busy@k+9"}, 32'(busy), 32'd0);
    check({tag, " bin@k+9"}, 32'(binary), 32'(exp_b));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_vec    = 0;
    n_miss   = 0;
    held_bin = 8'd0;
    held_err = 1'b0;
    rst_n    = 1'b0;
    start    = 1'b0;
    tens     = 4'd0;
    unit     = 4'd0;

    // Reset state
    #2;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst binary", 32'(binary), 32'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic conversion and boundaries
    conv("5,9", 4'd5, 4'd9, 8'd59, 1'b0, 9'b0);
    conv("0,0", 4'd0, 4'd0, 8'd0, 1'b0, 9'b0);
    conv("9,9", 4'd9, 4'd9, 8'd99, 1'b0, 9'b0);
    conv("1,0", 4'd1, 4'd0, 8'd10, 1'b0, 9'b0);

    // Invalid digit then recovery
    conv("A,3", 4'hA, 4'd3, 8'd0, 1'b1, 9'b0);
    conv("2,1", 4'd2, 4'd1, 8'd21, 1'b0, 9'b0);
    conv("3,F", 4'd3, 4'hF, 8'd0, 1'b1, 9'b0);
    conv("8,7", 4'd8, 4'd7, 8'd87, 1'b0, 9'b0);

    // Start pulses with 7,7 at k+3 and k+8 are ignored
    conv("4,2 intr", 4'd4, 4'd2, 8'd42, 1'b0, 9'b1_0000_1000);

    // Back-to-back with start held high: 1,2 then 3,4
    tens  = 4'd1;
    unit  = 4'd2;
    start = 1'b1;
    @(posedge clk); #1;
    tens = 4'd3;
    unit = 4'd4;
    for (int j = 1; j <= 7; j++) begin
      @(posedge clk); #1;
      check($sformatf("b2b first done@k+%0d", j), 32'(done), 32'd0);
    end
    @(posedge clk); #1;
    check("b2b done@k+8", 32'(done), 32'd1);
    check("b2b bin 12", 32'(binary), 32'd12);
    @(posedge clk); #1;
    check("b2b busy@k+9", 32'(busy), 32'd1);
    check("b2b done@k+9", 32'(done), 32'd0);
    start = 1'b0;
    for (int j = 10; j <= 16; j++) begin
      @(posedge clk); #1;
      check($sformatf("b2b second done@k+%0d", j), 32'(done), 32'd0);
      check($sformatf("b2b hold12@k+%0d", j), 32'(binary), 32'd12);
    end
    @(posedge clk); #1;
    check("b2b done@k+17", 32'(done), 32'd1);
    check("b2b bin 34", 32'(binary), 32'd34);
    check("b2b err", 32'(err), 32'd0);
    @(posedge clk); #1;
    check("b2b done@k+18", 32'(done), 32'd0);

    // Reset during a 6,0 conversion
    tens  = 4'd6;
    unit  = 4'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      @(posedge clk); #1;
    end
    check("abort pre bin", 32'(binary), 32'd34);
    check("abort pre busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort err", 32'(err), 32'd0);
    check("abort binary", 32'(binary), 32'd0);
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
      check($sformatf("abort no done %0d", j), 32'(done), 32'd0);
    end
    #2 rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
      check($sformatf("post rst idle done %0d", j), 32'(done), 32'd0);
      check($sformatf("post rst idle busy %0d", j), 32'(busy), 32'd0);
    end
    held_bin = 8'd0;
    held_err = 1'b0;
    conv("6,0 after rst", 4'd6, 4'd0, 8'd60, 1'b0, 9'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/bcd_decode.md
BCD_DECODE -- requirements
Module: bcd_decode

Interface
REQ-001 Parameter: N, default 8, width of the binary result; legal range 7..16 (7 covers 0..99).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a conversion; sampled only while idle.
REQ-005 tens  input  4  BCD tens digit; sampled on the accepted start edge.
REQ-006 unit  input  4  BCD units digit; sampled on the accepted start edge.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  one-cycle pulse; binary and err are valid from this cycle on.
REQ-009 err  output  1  high if either captured digit exceeded 9; held until the next accepted start.
REQ-010 binary  output  N  binary value tens*10+unit, zero-extended; held until the next done.

Function
REQ-011 Algorithm SHALL be sequential reverse double-dabble on a 16-bit work register {tens,unit,8'b0}, one right-shift per cycle, 8 shifts total.
REQ-012 After each shift, each BCD nibble (bits 15:12 and 11:8) that is >= 8 SHALL have 3 subtracted before the next shift.
REQ-013 After the 8th shift, work[7:0] SHALL be the result, zero-extended to N bits.
REQ-014 States SHALL be IDLE and SHIFT only; no other states.
REQ-015 IDLE: start=1 at edge k -> capture digits, clear the shift counter, set busy=1, go to SHIFT.
REQ-016 SHIFT: perform one shift and correction per edge, k+1 .. k+8; at edge k+8 load binary/err, set done=1, set busy=0, go to IDLE.
REQ-017 Latency SHALL be fixed: done rises at edge k+8 and falls at edge k+9, regardless of digit values.
REQ-018 start while busy=1 SHALL be ignored, including start at edge k+8; the captured digits SHALL NOT change mid-conversion.
REQ-019 start asserted in the done cycle (edge k+9) SHALL be accepted as a new conversion.
REQ-020 Invalid digit (tens>9 or unit>9) at capture: run the full 8 cycles, then present binary=0 and err=1 with the done pulse.
REQ-021 binary and err SHALL change only at a done edge; they SHALL be stable at all other times.
REQ-022 Holding start high continuously SHALL give back-to-back conversions with period 9 cycles.

Reset
REQ-023 rst_n low SHALL immediately force state=IDLE, busy=0, done=0, err=0, binary=0, counter=0, and work=0.
REQ-024 Reset asserted mid-conversion SHALL abort it with no done pulse; the first start after release SHALL behave as from power-up.
REQ-025 Deassertion of rst_n is synchronized externally; the block SHALL NOT accept start in the cycle of release unless rst_n is already high at that edge.

Structure
REQ-026 A shared package SHALL hold BCD_DIGIT_W=4, BCD_MAX_DIGIT=9, DECODE_SHIFTS=8, and the IDLE/SHIFT state encoding.
REQ-027 A combinational sub-module bcd_nibble_adjust SHALL implement the ">=8 then subtract 3" correction; it is instantiated twice.
REQ-028 The shift counter SHALL be 4 bits wide, with no arithmetic wider than 16 bits.
REQ-029 The expected implementation size is 120-400 lines of RTL.

Verification
REQ-030 tens=5, unit=9, start pulse -> busy for 8 cycles; done at k+8 with binary=59 (0x3B), err=0.
REQ-031 Boundaries: 0,0 -> binary=0; 9,9 -> binary=99 (0x63); both with err=0 and fixed 8-cycle latency.
REQ-032 tens=4'hA, unit=3 -> done at k+8 with binary=0, err=1; a following 2,1 conversion -> binary=21, err=0.
REQ-033 Convert 4,2, then pulse start with 7,7 at edges k+3 and k+8 -> only 42 is produced, and busy/binary are unaffected.
REQ-034 start held high with digits 1,2 then 3,4 -> done pulses 9 cycles apart with binary 12 then 34.
REQ-035 rst_n low at k+4 of a 6,0 conversion -> all outputs 0 at once, no done; after release, 6,0 -> binary=60 at k+8.
